// File: rtl/mem_access_stage.sv
// mem_access_stage
//   MEM pipeline stage. Takes the EX/MEM register outputs (me_*) and drives a
//   32-bit data-memory port. Scalar loads/stores take one bus beat; MAT_W-bit
//   matrix loads/stores are split into MAT_W/32 sequential beats. Upstream
//   stages are stalled while an access is in flight, and results are
//   registered into the MEM/WB boundary.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   me_*              EX/MEM register outputs (held stable while stall_o=1)
//   fwd_wb_data       forwarded WB data, used as store data when me_rs2_r_select=1
//   dmem_*            data-memory request/response port (dmem_ready = beat accepted)
//   stall_o           freezes PC, IF/ID, ID/EX and EX/MEM
//   wb_*              MEM/WB register outputs
//   misalign_o        one-cycle misaligned-access flag
module mem_access_stage #(
    parameter int MAT_W  = 128,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       me_alu_o,
    input  logic [31:0]       me_regs_data2,
    input  logic [31:0]       fwd_wb_data,
    input  logic              me_rs2_r_select,
    input  logic [MAT_W-1:0]  me_matrix_o,
    input  logic [4:0]        me_rd,
    input  logic              me_mem_read,
    input  logic              me_mem_write,
    input  logic              me_mem2reg,
    input  logic [1:0]        me_w_select,
    input  logic [2:0]        me_func3_code,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_wstrb,
    input  logic              dmem_ready,
    input  logic [31:0]       dmem_rdata,
    output logic              stall_o,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic [MAT_W-1:0]  wb_matrix,
    output logic [1:0]        wb_w_select,
    output logic              wb_mem2reg,
    output logic              misalign_o
);

    localparam int BEATS = MAT_W / 32;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]       state;
    logic [BW-1:0]    beat;
    logic [MAT_W-1:0] mat_buf;

    logic             mem_op;
    logic             is_matrix;
    logic             is_store;
    logic             is_load;
    logic             misaligned;
    logic             start;
    logic             beat_done;
    logic             final_done;

    logic [31:0]      store_src;
    logic [31:0]      scalar_wdata;
    logic [3:0]       scalar_strb;
    logic [31:0]      mat_word;
    logic [7:0]       load_byte;
    logic [15:0]      load_half;
    logic [31:0]      load_data;
    logic [MAT_W-1:0] assembled;

    // Access classification and beat bookkeeping
    always_comb begin
        mem_op    = me_mem_read | me_mem_write;
        is_matrix = (me_w_select == 2'b10);
        // read+write together behaves as a store
        is_store  = me_mem_write;
        is_load   = me_mem_read & ~me_mem_write;

        if (is_matrix) begin
            misaligned = (me_alu_o[3:0] != 4'h0);
        end else begin
            case (me_func3_code[1:0])
                2'b00:   misaligned = 1'b0;
                2'b01:   misaligned = me_alu_o[0];
                default: misaligned = (me_alu_o[1:0] != 2'b00);
            endcase
        end

        start      = (state == IDLE) & mem_op & ~misaligned;
        // dmem_req is exactly state==BUSY, so ready outside BUSY is ignored
        beat_done  = (state == BUSY) & dmem_ready;
        final_done = beat_done & (~is_matrix | (beat == LAST_BEAT));
    end

    // Store data formatting
    always_comb begin
        store_src = me_rs2_r_select ? fwd_wb_data : me_regs_data2;
        case (me_func3_code[1:0])
            2'b00: begin
                scalar_wdata = {4{store_src[7:0]}};
                scalar_strb  = 4'b0001 << me_alu_o[1:0];
            end
            2'b01: begin
                scalar_wdata = {2{store_src[15:0]}};
                scalar_strb  = me_alu_o[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                scalar_wdata = store_src;
                scalar_strb  = 4'b1111;
            end
        endcase

        mat_word = '0;
        for (int unsigned i = 0; i < BEATS; i++) begin
            if (beat == BW'(i)) begin
                mat_word = me_matrix_o[32*i +: 32];
            end
        end
    end

    // Load data extraction; the final matrix beat bypasses the buffer
    always_comb begin
        case (me_alu_o[1:0])
            2'b00:   load_byte = dmem_rdata[7:0];
            2'b01:   load_byte = dmem_rdata[15:8];
            2'b10:   load_byte = dmem_rdata[23:16];
            default: load_byte = dmem_rdata[31:24];
        endcase
        load_half = me_alu_o[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

        case (me_func3_code)
            3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_data = {{16{load_half[15]}}, load_half};
            3'b100:  load_data = {24'h0, load_byte};
            3'b101:  load_data = {16'h0, load_half};
            default: load_data = dmem_rdata;
        endcase

        assembled = mat_buf;
        assembled[MAT_W-1 -: 32] = dmem_rdata;
    end

    // Bus and stall outputs
    always_comb begin
        dmem_req   = (state == BUSY);
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        dmem_wstrb = '0;
        if (dmem_req) begin
            dmem_we   = me_mem_write;
            dmem_addr = ADDR_W'({me_alu_o[31:2], 2'b00} + (32'(beat) << 2));
            if (is_store) begin
                dmem_wdata = is_matrix ? mat_word : scalar_wdata;
                dmem_wstrb = is_matrix ? 4'b1111 : scalar_strb;
            end
        end
        // gated by rst so every output reads 0 while reset is held
        stall_o = ~rst & (start | ((state == BUSY) & ~final_done));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            beat        <= '0;
            mat_buf     <= '0;
            wb_valid    <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            wb_matrix   <= '0;
            wb_w_select <= '0;
            wb_mem2reg  <= 1'b0;
            misalign_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    misalign_o <= mem_op & misaligned;
                    if (mem_op) begin
                        // bubble while the access runs, or drop on misalignment
                        wb_valid <= 1'b0;
                        wb_rd    <= '0;
                        if (!misaligned) begin
                            state <= BUSY;
                            beat  <= '0;
                        end
                    end else begin
                        wb_valid    <= 1'b1;
                        wb_rd       <= me_rd;
                        wb_data     <= me_alu_o;
                        wb_matrix   <= me_matrix_o;
                        wb_w_select <= me_w_select;
                        wb_mem2reg  <= me_mem2reg;
                    end
                end
                default: begin
                    misalign_o <= 1'b0;
                    if (beat_done) begin
                        if (is_matrix && is_load) begin
                            for (int unsigned i = 0; i < BEATS; i++) begin
                                if (beat == BW'(i)) begin
                                    mat_buf[32*i +: 32] <= dmem_rdata;
                                end
                            end
                        end
                        if (final_done) begin
                            state       <= IDLE;
                            beat        <= '0;
                            wb_valid    <= 1'b1;
                            wb_rd       <= (is_matrix && is_store) ? 5'd0 : me_rd;
                            wb_data     <= (is_load && !is_matrix) ? load_data : me_alu_o;
                            wb_matrix   <= (is_load && is_matrix) ? assembled : me_matrix_o;
                            wb_w_select <= me_w_select;
                            wb_mem2reg  <= me_mem2reg;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM pipeline stage. Consumes the EX/MEM register outputs (me_*) and drives the data-memory port.
- Registers results into the MEM/WB boundary.
- Scalar loads and stores take one bus beat. 128-bit matrix loads and stores are split into sequential 32-bit beats by an FSM, and upstream stages are stalled until the access completes.

Parameters:
- MAT_W, 128, matrix operand width; must be a multiple of 32; beats = MAT_W/32.
- ADDR_W, 32, data-memory address width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- me_alu_o  in  32  effective address, or ALU result
- me_regs_data2  in  32  store data from the register file
- fwd_wb_data  in  32  forwarded WB data; replaces store data when me_rs2_r_select=1
- me_rs2_r_select  in  1  store-data forward select
- me_matrix_o  in  MAT_W  matrix result, or matrix store data
- me_rd  in  5  destination register
- me_mem_read  in  1  load
- me_mem_write  in  1  store
- me_mem2reg  in  1  writeback from memory
- me_w_select  in  2  00 ALU, 01 scalar memory, 10 matrix, 11 reserved (treated as 00)
- me_func3_code  in  3  load/store size and sign
- dmem_req  out  1  bus request
- dmem_we  out  1  write enable
- dmem_addr  out  ADDR_W  word-aligned address
- dmem_wdata  out  32  write data
- dmem_wstrb  out  4  byte strobes
- dmem_ready  in  1  beat accepted / read data valid this cycle
- dmem_rdata  in  32  read data
- stall_o  out  1  freezes PC, IF/ID, ID/EX and EX/MEM
- wb_valid  out  1  MEM/WB entry valid
- wb_rd  out  5  destination register
- wb_data  out  32  scalar writeback data
- wb_matrix  out  MAT_W  matrix writeback data
- wb_w_select  out  2  passed through
- wb_mem2reg  out  1  passed through
- misalign_o  out  1  one-cycle misaligned-access flag

Behaviour:
- Reset: all outputs 0; FSM returns to IDLE. Reset mid-access drops dmem_req immediately and discards partial matrix data.
- FSM states: IDLE, BUSY. Beat counter is log2(beats) bits.
- mem_op = me_mem_read | me_mem_write.
  - mem_op with me_w_select=10 is a matrix op.
  - Otherwise mem_op is a scalar op.
- IDLE, no mem_op: at the next edge, wb_* register the inputs; wb_valid=1; wb_data=me_alu_o; wb_matrix=me_matrix_o. Latency is 1 cycle.
- IDLE, aligned mem_op:
  - stall_o=1 combinationally.
  - Next edge: enter BUSY, beat=0. wb_valid=0 and wb_rd=0 (bubble).
- BUSY, request:
  - dmem_req=1 and dmem_we=me_mem_write.
  - dmem_addr = {me_alu_o[31:2],2'b00} + 4*beat.
- BUSY, beat completion:
  - A beat completes in a cycle with dmem_req & dmem_ready. dmem_ready without dmem_req is ignored.
  - Matrix load: a completed beat captures dmem_rdata into buffer bits [32*beat+31:32*beat].
- BUSY, stall release:
  - stall_o stays 1 except in the cycle the final beat completes.
  - In that cycle stall_o=0. At the following edge the FSM returns to IDLE and the results register to WB with wb_valid=1.
- Matrix store: beat i writes me_matrix_o[32i+31:32i] with wstrb=1111. me_func3_code is ignored. No register writeback: wb_valid=1, wb_rd=0.
- Matrix load: wb_matrix = assembled buffer. The final beat's rdata goes straight into bits [MAT_W-1:MAT_W-32] of wb_matrix.
- Scalar store data: fwd_wb_data when me_rs2_r_select=1, else me_regs_data2. The data is replicated into byte lanes.
  - func3 000 SB: strobe = 1<<a[1:0].
  - func3 001 SH: strobe = 0011 or 1100 by a[1].
  - func3 010 SW: strobe = 1111.
- Scalar load (wstrb=0): lane-select by a[1:0].
  - 000 LB, sign-extend.
  - 001 LH, sign-extend.
  - 010 LW.
  - 100 LBU, zero-extend.
  - 101 LHU, zero-extend.
  - Other func3 values behave as LW.
- Alignment rules (a = me_alu_o):
  - Halfword with a[0]=1 is misaligned.
  - Word with a[1:0]≠0 is misaligned.
  - Matrix with a[3:0]≠0 is misaligned.
- Misaligned access:
  - No bus request and no stall.
  - Next edge: misalign_o=1 for one cycle; wb_valid=0.
- Timing rules:
  - Stall lasts at least beats cycles (matrix) or 1 cycle (scalar), plus dmem wait cycles.
  - Inputs are held stable by the stall; the block does not latch me_*.
  - Simultaneous mem_read and mem_write is treated as a store.

Test Plan:
1. Non-memory op: me_alu_o=0x1234, me_rd=5, w_select=00 → next cycle wb_valid=1, wb_rd=5, wb_data=0x00001234; stall_o never asserted.
2. LB at 0x103, dmem_ready tied 1, rdata=0x80FF00AA → dmem_addr=0x100; stall_o high 1 cycle; wb_data=0xFFFFFF80. LBU at the same address → 0x00000080.
3. SH at 0x102 with me_rs2_r_select=1, fwd_wb_data=0xABCD → dmem_wdata=0xABCDABCD, wstrb=1100, dmem_we=1.
4. Matrix load at 0x200, ready=1 every cycle, rdata beats 0x11,0x22,0x33,0x44 → addresses 0x200/204/208/20C; stall_o high 4 cycles; wb_matrix=0x00000044_00000033_00000022_00000011.
5. Matrix store at 0x300 with ready low for 2 cycles on beat 1 → beat-1 address and data held for 3 cycles; total stall 6 cycles; wb_rd=0.
6. LW at 0x102 → no dmem_req, misalign_o=1 for one cycle. Separately, rst asserted mid-matrix beat 2 → dmem_req=0 immediately, all outputs 0, FSM in IDLE.
